// File: rtl/rom_burst_reader.sv
// rom_burst_reader: walks a 32x8 ROM from a start address and streams the
// bytes out over valid/ready, keeping a mod-256 checksum of delivered bytes.
//
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   start             - burst request (taken only when idle)
//   start_addr[4:0]   - first ROM address of the burst
//   length[5:0]       - byte count, 0..32 (larger values clamp to 32)
//   addrb[4:0]        - ROM address (always the current fetch pointer)
//   read_en           - ROM read enable, high only while fetching
//   datab[7:0]        - ROM read data (combinational from addrb/read_en)
//   out_data[7:0]     - captured byte for the consumer
//   out_valid         - out_data is valid
//   out_ready         - consumer accepts out_data
//   busy              - engine is not idle
//   done              - one-cycle pulse at burst completion
//   checksum[7:0]     - running sum of accepted bytes in current/last burst
module rom_burst_reader (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] start_addr,
  input  logic [5:0] length,
  output logic [4:0] addrb,
  output logic       read_en,
  input  logic [7:0] datab,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] checksum
);

  localparam int unsigned AW      = 5;
  localparam int unsigned DW      = 8;
  localparam int unsigned LW      = 6;
  localparam int unsigned MAX_LEN = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] rem_q, rem_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] cks_q, cks_d;
  logic          read_en_q, read_en_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      data_q    <= '0;
      cks_q     <= '0;
      read_en_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      data_q    <= data_d;
      cks_q     <= cks_d;
      read_en_q <= read_en_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    cks_d   = cks_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cks_d = '0;
          if (length == '0) begin
            state_d = S_DONE;
          end else begin
            addr_d  = start_addr;
            rem_d   = (length > LW'(MAX_LEN)) ? LW'(MAX_LEN) : length;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        data_d  = datab;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        // out_valid is high throughout HOLD, so out_ready alone marks a transfer.
        if (out_ready) begin
          cks_d   = cks_q + data_q;
          rem_d   = rem_q - LW'(1);
          addr_d  = addr_q + AW'(1);
          state_d = (rem_q > LW'(1)) ? S_FETCH : S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status flags are registered from the next state so they align with it.
  always_comb begin
    read_en_d = (state_d == S_FETCH);
    valid_d   = (state_d == S_HOLD);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  assign addrb     = addr_q;
  assign read_en   = read_en_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign checksum  = cks_q;

endmodule

// File: doc/rom_burst_reader.md
# rom_burst_reader

Sequential fetch engine sitting directly upstream of the 32x8 ROM (`ROM_32x8`). It drives the ROM's 5-bit address and read enable, and captures the 8-bit read data. It streams a burst of consecutive bytes to a downstream consumer over a valid/ready handshake. It also keeps a running modulo-256 checksum of the bytes delivered.

## Interface
- No parameters; address width 5, data width 8, fixed by the ROM.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `start`  input  1  burst request, sampled only in IDLE.
- `start_addr`  input  5  first ROM address of the burst, sampled with `start`.
- `length`  input  6  number of bytes, 0..32, sampled with `start`.
- `addrb`  output  5  ROM address; connects to ROM `addrb`.
- `read_en`  output  1  ROM read enable; connects to ROM `read_en`.
- `datab`  input  8  ROM read data; combinational from `addrb`/`read_en`.
- `out_data`  output  8  captured byte.
- `out_valid`  output  1  `out_data` is valid.
- `out_ready`  input  1  consumer accepts `out_data`.
- `busy`  output  1  high in any state other than IDLE.
- `done`  output  1  one-cycle pulse when a burst completes.
- `checksum`  output  8  sum modulo 256 of bytes accepted in the current or last burst.

## Operation
- States: IDLE, FETCH, HOLD, DONE.
- IDLE:
  - `start`=1 and `length`≠0 -> load `addr_reg`<=`start_addr`, `remaining`<=`length`, `checksum`<=0; go to FETCH.
  - `start`=1 and `length`=0 -> `checksum`<=0; go to DONE.
  - `start`=0 -> stay in IDLE.
- FETCH:
  - `read_en`=1 and `addrb`=`addr_reg`.
  - At the clock edge: `out_data`<=`datab`; go to HOLD.
- HOLD:
  - `out_valid`=1 and `read_en`=0.
  - A transfer happens at an edge where `out_valid`&`out_ready`=1. On a transfer:
    - `checksum`<=`checksum`+`out_data` (8-bit wrap).
    - `remaining`<=`remaining`-1.
    - `addr_reg`<=`addr_reg`+1 (wraps 31->0).
    - Go to FETCH if `remaining`>1, else go to DONE.
  - Without a transfer: stay in HOLD; `out_data` is held stable.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` asserted while `busy`=1 is ignored; no queueing.
- `read_en` is high only in FETCH. `addrb` always equals `addr_reg`.
- `checksum` holds its value in IDLE after a burst until the next `start`.
- Width rule: `remaining` is 6 bits, so `length`=32 is legal. Values above 32 are clamped to 32.

## Timing
- Reset values:
  - state=IDLE, `addrb`=0, `read_en`=0, `out_data`=0, `out_valid`=0.
  - `busy`=0, `done`=0, `checksum`=0, `remaining`=0.
- `start` sampled at edge k: FETCH during cycle k+1. `out_valid`=1 from cycle k+2.
- First-byte latency: 2 cycles from the `start` edge.
- Throughput with `out_ready` held high: 1 byte per 2 cycles. An N-byte burst occupies 2N+1 cycles from `start` through `done`.
- `done` is asserted the cycle after the final transfer edge. `busy` falls in the following cycle.
- Address wrap: `start_addr`=30, `length`=4 reads addresses 30, 31, 0, 1.
- `reset` mid-burst:
  - Next cycle is IDLE with all outputs at their reset values.
  - No `done` pulse; any pending byte is discarded.
- `out_ready` may toggle freely. `out_valid` never drops without a transfer, except on `reset`.

## Test plan
- Reset with `out_valid` pending -> next cycle `out_valid`=0, `busy`=0, `addrb`=0, `read_en`=0, `checksum`=0.
- `start_addr`=0, `length`=4, `out_ready`=1, ROM model loaded with 0x11/0x22/0x33/0x44 -> bytes 0x11, 0x22, 0x33, 0x44 on cycles k+2, k+4, k+6, k+8; `done` at k+9; `checksum`=0xAA.
- `start_addr`=30, `length`=4 -> `addrb` sequence 30, 31, 0, 1 during FETCH cycles; `read_en` is low in every HOLD cycle.
- `out_ready` held low for 5 cycles after the first `out_valid` -> `out_data` stable, no address advance, `checksum` unchanged; the transfer occurs on the first edge with `out_ready`=1.
- `length`=0 -> `done` pulses at k+1, `out_valid` never asserted, `checksum`=0; a second `start` during `busy` is ignored.
- `length`=32 with ROM filled with 0xFF -> 32 transfers, `checksum`=0xE0; `addrb` returns to `start_addr` after wrapping.
